// File: rtl/nf10_nic_input_arbiter_if.sv
// rtl/nf10_nic_input_arbiter_if.sv - AXI4-Stream beat bundle shared by the arbiter inputs and output
interface nf10_nic_input_arbiter_if #(
   parameter int DATA_WIDTH  = 256,
   parameter int TUSER_WIDTH = 128
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [TUSER_WIDTH-1:0]  tuser;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;

   modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_nic_input_arbiter.sv
// rtl/nf10_nic_input_arbiter.sv - three-input round-robin packet arbiter with a 2-entry output buffer
module nf10_nic_input_arbiter #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
   input  logic                     axi_aclk,
   input  logic                     axi_resetn,
   nf10_nic_input_arbiter_if.slave  s_axis_0,
   nf10_nic_input_arbiter_if.slave  s_axis_1,
   nf10_nic_input_arbiter_if.slave  s_axis_2,
   nf10_nic_input_arbiter_if.master m_axis
);
   localparam int IN_W   = C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH / 8 + C_S_AXIS_TUSER_WIDTH + 1;
   localparam int BEAT_W = C_M_AXIS_DATA_WIDTH + C_M_AXIS_DATA_WIDTH / 8 + C_M_AXIS_TUSER_WIDTH + 1;

   typedef enum logic {IDLE, PKT} state_t;

   state_t            state_q, state_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [1:0]        grant_q, grant_d;
   logic [1:0]        buf_count_q, buf_count_d;
   logic [BEAT_W-1:0] head_q, head_d;
   logic [BEAT_W-1:0] tail_q, tail_d;

   logic [3:0]           in_valid;
   logic [3:0][IN_W-1:0] in_beat;
   logic                 sel_valid;
   logic [IN_W-1:0]      sel_beat;
   logic                 push;
   logic                 pop;
   logic [2:0]           s_ready;

   function automatic logic [1:0] next_port(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Slot 3 is a dead entry so a 2-bit index never selects outside the arrays.
   assign in_valid   = {1'b0, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
   assign in_beat[0] = {s_axis_0.tdata, s_axis_0.tstrb, s_axis_0.tuser, s_axis_0.tlast};
   assign in_beat[1] = {s_axis_1.tdata, s_axis_1.tstrb, s_axis_1.tuser, s_axis_1.tlast};
   assign in_beat[2] = {s_axis_2.tdata, s_axis_2.tstrb, s_axis_2.tuser, s_axis_2.tlast};
   assign in_beat[3] = '0;
   assign sel_valid  = in_valid[grant_q];
   assign sel_beat   = in_beat[grant_q];

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q     <= IDLE;
         rr_ptr_q    <= 2'd0;
         grant_q     <= 2'd0;
         buf_count_q <= 2'd0;
         head_q      <= '0;
         tail_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         buf_count_q <= buf_count_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      buf_count_d = buf_count_q;
      head_d      = head_q;
      tail_d      = tail_q;
      push        = (state_q == PKT) && sel_valid && (buf_count_q != 2'd2);
      pop         = (buf_count_q != 2'd0) && m_axis.tready;

      case (state_q)
         IDLE: begin
            if (|in_valid) begin
               if (in_valid[rr_ptr_q])
                  grant_d = rr_ptr_q;
               else if (in_valid[next_port(rr_ptr_q)])
                  grant_d = next_port(rr_ptr_q);
               else
                  grant_d = next_port(next_port(rr_ptr_q));
               state_d = PKT;
            end
         end
         PKT: begin
            if (push && sel_beat[0]) begin
               rr_ptr_d = next_port(grant_q);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Push with pop only happens at count 1 because a full buffer holds tready low.
      case ({push, pop})
         2'b10: begin
            if (buf_count_q == 2'd0)
               head_d = sel_beat;
            else
               tail_d = sel_beat;
            buf_count_d = buf_count_q + 2'd1;
         end
         2'b01: begin
            if (buf_count_q == 2'd2)
               head_d = tail_q;
            buf_count_d = buf_count_q - 2'd1;
         end
         2'b11: head_d = sel_beat;
         default: ;
      endcase
   end

   always_comb begin
      s_ready = 3'b000;
      if (state_q == PKT && buf_count_q != 2'd2) begin
         case (grant_q)
            2'd0:    s_ready[0] = 1'b1;
            2'd1:    s_ready[1] = 1'b1;
            2'd2:    s_ready[2] = 1'b1;
            default: ;
         endcase
      end
   end

   assign s_axis_0.tready = s_ready[0];
   assign s_axis_1.tready = s_ready[1];
   assign s_axis_2.tready = s_ready[2];
   assign m_axis.tvalid   = (buf_count_q != 2'd0);
   assign {m_axis.tdata, m_axis.tstrb, m_axis.tuser, m_axis.tlast} = head_q;
endmodule

// File: tb/tb_nf10_nic_input_arbiter.sv
// tb/tb_nf10_nic_input_arbiter.sv - directed self-checking bench for nf10_nic_input_arbiter
module tb_nf10_nic_input_arbiter;
   typedef struct packed {
      logic [255:0] d;
      logic [31:0]  s;
      logic [127:0] u;
      logic         l;
   } beat_t;

   logic clk;
   logic axi_resetn;

   nf10_nic_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s0();
   nf10_nic_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s1();
   nf10_nic_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s2();
   nf10_nic_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) m();

   nf10_nic_input_arbiter dut (
      .axi_aclk   (clk),
      .axi_resetn (axi_resetn),
      .s_axis_0   (s0),
      .s_axis_1   (s1),
      .s_axis_2   (s2),
      .m_axis     (m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_checks;
   int     n_fails;
   int     cycle;
   int     bench_count;
   bit [2:0] acc_now;
   bit     pop_now;
   int     idx[3];
   int     gap_after[3];
   int     gap_len[3];
   int     gap_cnt[3];
   beat_t  src0[$];
   beat_t  src1[$];
   beat_t  src2[$];
   beat_t  out_q[$];
   int     out_cyc[$];
   int     acc_cyc[$];
   int     acc_src[$];
   int     pat[$];

   function automatic logic [31:0] idf(int src, int pkt, int b);
      return 32'(src * 65536 + pkt * 256 + b);
   endfunction

   function automatic beat_t mk(int src, int pkt, int b, bit last, logic [127:0] user);
      beat_t r;
      logic [31:0] id;
      id  = idf(src, pkt, b);
      r.d = {~id, {6{id ^ 32'h5A5A_C3C3}}, id};
      r.s = last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      r.u = user;
      r.l = last;
      return r;
   endfunction

   function automatic int src_size(int i);
      case (i)
         0:       return src0.size();
         1:       return src1.size();
         default: return src2.size();
      endcase
   endfunction

   function automatic beat_t src_at(int i, int k);
      case (i)
         0:       return src0[k];
         1:       return src1[k];
         default: return src2[k];
      endcase
   endfunction

   task automatic push_pkt(input int src, input int pkt, input int n, input logic [127:0] user);
      for (int b = 0; b < n; b++) begin
         case (src)
            0:       src0.push_back(mk(src, pkt, b, b == n - 1, user));
            1:       src1.push_back(mk(src, pkt, b, b == n - 1, user));
            default: src2.push_back(mk(src, pkt, b, b == n - 1, user));
         endcase
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 3; i++) begin
         beat_t b;
         bit    v;
         v = 1'b0;
         b = '0;
         if (idx[i] < src_size(i)) begin
            if (idx[i] == gap_after[i] && gap_cnt[i] < gap_len[i])
               gap_cnt[i]++;
            else begin
               v = 1'b1;
               b = src_at(i, idx[i]);
            end
         end
         case (i)
            0: begin s0.tvalid = v; {s0.tdata, s0.tstrb, s0.tuser, s0.tlast} = b; end
            1: begin s1.tvalid = v; {s1.tdata, s1.tstrb, s1.tuser, s1.tlast} = b; end
            default: begin s2.tvalid = v; {s2.tdata, s2.tstrb, s2.tuser, s2.tlast} = b; end
         endcase
      end
   endtask

   task automatic sample_edge();
      @(negedge clk);
      acc_now = {s2.tvalid & s2.tready, s1.tvalid & s1.tready, s0.tvalid & s0.tready};
      pop_now = m.tvalid & m.tready;
      if (pop_now) begin
         out_q.push_back({m.tdata, m.tstrb, m.tuser, m.tlast});
         out_cyc.push_back(cycle);
      end
      for (int i = 0; i < 3; i++) begin
         if (acc_now[i]) begin
            acc_cyc.push_back(cycle);
            acc_src.push_back(i);
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      bench_count = bench_count + $countones(acc_now) - (pop_now ? 1 : 0);
      for (int i = 0; i < 3; i++)
         if (acc_now[i]) idx[i]++;
      acc_now = '0;
      pop_now = 1'b0;
      cycle++;
      drive_inputs();
      m.tready = (pat.size() == 0) ? 1'b1 : (pat[cycle % pat.size()] != 0);
   endtask

   task automatic run_until(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (out_q.size() < n && k < budget) begin
         sample_edge();
         advance();
         k++;
      end
      ok = (out_q.size() >= n);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      axi_resetn = 1'b0;
      src0.delete(); src1.delete(); src2.delete();
      out_q.delete(); out_cyc.delete(); acc_cyc.delete(); acc_src.delete(); pat.delete();
      for (int i = 0; i < 3; i++) begin
         idx[i] = 0; gap_after[i] = -1; gap_len[i] = 0; gap_cnt[i] = 0;
      end
      bench_count = 0;
      acc_now = '0;
      pop_now = 1'b0;
      cycle = 0;
      drive_inputs();
      m.tready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      axi_resetn = 1'b1;
   endtask

   task automatic test_reset();
      axi_resetn = 1'b0;
      s0.tvalid = 1'b1; s1.tvalid = 1'b1; s2.tvalid = 1'b1;
      m.tready = 1'b1;
      #2;
      n_checks++; if (m.tvalid !== 1'b0) begin n_fails++; $display("FAIL reset_tvalid: got %b want 0", m.tvalid); end
      n_checks++; if (m.tdata !== 256'h0) begin n_fails++; $display("FAIL reset_tdata: got %h want 0", m.tdata); end
      n_checks++; if (m.tstrb !== 32'h0) begin n_fails++; $display("FAIL reset_tstrb: got %h want 0", m.tstrb); end
      n_checks++; if (m.tuser !== 128'h0) begin n_fails++; $display("FAIL reset_tuser: got %h want 0", m.tuser); end
      n_checks++; if (m.tlast !== 1'b0) begin n_fails++; $display("FAIL reset_tlast: got %b want 0", m.tlast); end
      n_checks++; if ({s2.tready, s1.tready, s0.tready} !== 3'b000) begin
         n_fails++; $display("FAIL reset_tready: got %b want 000", {s2.tready, s1.tready, s0.tready});
      end
   endtask

   task automatic test_single();
      bit ok;
      do_reset();
      push_pkt(0, 0, 4, 128'h0104);
      drive_inputs();
      n_checks++; if (s0.tready !== 1'b0) begin n_fails++; $display("FAIL single_tready_idle: got %b want 0", s0.tready); end
      sample_edge();
      advance();
      n_checks++; if (s0.tready !== 1'b1) begin n_fails++; $display("FAIL single_tready_rise: got %b want 1", s0.tready); end
      run_until(4, 40, ok);
      n_checks++; if (!ok) begin n_fails++; $display("FAIL single_timeout: got %0d beats want 4", out_q.size()); return; end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (out_q[k] !== src0[k]) begin n_fails++; $display("FAIL single_beat%0d: got %h want %h", k, out_q[k], src0[k]); end
      end
      n_checks++; if (out_q[3].u !== 128'h0104 || out_q[3].l !== 1'b1) begin
         n_fails++; $display("FAIL single_tuser_tlast: got %h/%b want 0104/1", out_q[3].u, out_q[3].l);
      end
      n_checks++; if (out_cyc[0] !== acc_cyc[0] + 1) begin
         n_fails++; $display("FAIL single_latency: got %0d want %0d", out_cyc[0] - acc_cyc[0], 1);
      end
      n_checks++; if (acc_cyc[3] - acc_cyc[0] !== 3) begin
         n_fails++; $display("FAIL single_throughput: got %0d cycles want 3", acc_cyc[3] - acc_cyc[0]);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 3; i++)
            push_pkt(i, p, 2, 128'h0A00 + 128'(i));
      drive_inputs();
      run_until(12, 100, ok);
      n_checks++; if (!ok) begin n_fails++; $display("FAIL rr_timeout: got %0d beats want 12", out_q.size()); return; end
      for (int k = 0; k < 6; k++) begin
         for (int b = 0; b < 2; b++) begin
            n_checks++;
            if (out_q[2 * k + b].d[31:0] !== idf(k % 3, k / 3, b)) begin
               n_fails++; $display("FAIL rr_order pkt%0d beat%0d: got %h want %h", k, b, out_q[2 * k + b].d[31:0], idf(k % 3, k / 3, b));
            end
         end
      end
      for (int k = 1; k < 6; k++) begin
         n_checks++;
         if (acc_cyc[2 * k] !== acc_cyc[2 * k - 1] + 2) begin
            n_fails++; $display("FAIL rr_bubble pkt%0d: got gap %0d want 2", k, acc_cyc[2 * k] - acc_cyc[2 * k - 1]);
         end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      do_reset();
      push_pkt(2, 0, 2, 128'h0B02);
      drive_inputs();
      run_until(2, 30, ok);
      n_checks++; if (!ok) begin n_fails++; $display("FAIL wrap_first_timeout: got %0d beats want 2", out_q.size()); return; end
      push_pkt(0, 1, 2, 128'h0B00);
      push_pkt(2, 1, 2, 128'h0B02);
      drive_inputs();
      run_until(6, 40, ok);
      n_checks++; if (!ok) begin n_fails++; $display("FAIL wrap_timeout: got %0d beats want 6", out_q.size()); return; end
      n_checks++; if (out_q[2].d[31:0] !== idf(0, 1, 0)) begin
         n_fails++; $display("FAIL wrap_next_grant: got %h want %h", out_q[2].d[31:0], idf(0, 1, 0));
      end
      n_checks++; if (out_q[4].d[31:0] !== idf(2, 1, 0)) begin
         n_fails++; $display("FAIL wrap_then_2: got %h want %h", out_q[4].d[31:0], idf(2, 1, 0));
      end
   endtask

   task automatic test_backpressure();
      bit    prev_stall;
      beat_t prev_beat;
      beat_t cur;
      int    k;
      int    full_seen;
      prev_stall = 1'b0;
      prev_beat  = '0;
      full_seen  = 0;
      k = 0;
      do_reset();
      pat = '{1, 0, 0, 1, 0, 1};
      push_pkt(1, 0, 8, 128'h0C01);
      drive_inputs();
      while (out_q.size() < 8 && k < 200) begin
         sample_edge();
         cur = {m.tdata, m.tstrb, m.tuser, m.tlast};
         if (bench_count == 2) begin
            full_seen++;
            n_checks++; if (s1.tready !== 1'b0) begin n_fails++; $display("FAIL bp_tready_full cyc%0d: got %b want 0", cycle, s1.tready); end
         end
         n_checks++; if (m.tvalid !== (bench_count != 0)) begin
            n_fails++; $display("FAIL bp_tvalid cyc%0d: got %b want %b", cycle, m.tvalid, bench_count != 0);
         end
         if (prev_stall) begin
            n_checks++; if (cur !== prev_beat) begin n_fails++; $display("FAIL bp_stable cyc%0d: got %h want %h", cycle, cur, prev_beat); end
         end
         prev_stall = m.tvalid & ~m.tready;
         prev_beat  = cur;
         advance();
         k++;
      end
      n_checks++; if (out_q.size() !== 8) begin n_fails++; $display("FAIL bp_count: got %0d beats want 8", out_q.size()); return; end
      n_checks++; if (full_seen == 0) begin n_fails++; $display("FAIL bp_fill: got %0d full cycles want >0", full_seen); end
      for (int j = 0; j < 8; j++) begin
         n_checks++;
         if (out_q[j] !== src1[j]) begin n_fails++; $display("FAIL bp_beat%0d: got %h want %h", j, out_q[j].d[31:0], src1[j].d[31:0]); end
      end
   endtask

   task automatic test_gaps();
      bit ok;
      int last0;
      int first1;
      int n0;
      last0  = -1;
      first1 = -1;
      n0     = 0;
      do_reset();
      push_pkt(0, 0, 4, 128'h0D00);
      push_pkt(1, 0, 2, 128'h0D01);
      gap_after[0] = 1;
      gap_len[0]   = 3;
      drive_inputs();
      run_until(6, 60, ok);
      n_checks++; if (!ok) begin n_fails++; $display("FAIL gap_timeout: got %0d beats want 6", out_q.size()); return; end
      for (int j = 0; j < acc_src.size(); j++) begin
         if (acc_src[j] == 0) begin
            last0 = acc_cyc[j];
            if (n0 == 1) begin
               n_checks++; if (acc_cyc[j] - acc_cyc[j - 1] !== 4) begin
                  n_fails++; $display("FAIL gap_hold: got %0d cycles want 4", acc_cyc[j] - acc_cyc[j - 1]);
               end
            end
            n0++;
         end
         if (acc_src[j] == 1 && first1 < 0) first1 = acc_cyc[j];
      end
      n_checks++; if (!(first1 > last0)) begin
         n_fails++; $display("FAIL gap_no_switch: got first1 %0d want after %0d", first1, last0);
      end
      for (int j = 0; j < 6; j++) begin
         n_checks++;
         if (out_q[j].d[31:0] !== ((j < 4) ? idf(0, 0, j) : idf(1, 0, j - 4))) begin
            n_fails++; $display("FAIL gap_order%0d: got %h want %h", j, out_q[j].d[31:0], (j < 4) ? idf(0, 0, j) : idf(1, 0, j - 4));
         end
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      int k;
      k = 0;
      do_reset();
      push_pkt(0, 0, 2, 128'h0E00);
      drive_inputs();
      run_until(2, 30, ok);
      n_checks++; if (!ok) begin n_fails++; $display("FAIL ar_pre_timeout: got %0d beats want 2", out_q.size()); return; end
      pat = '{0};
      push_pkt(1, 0, 8, 128'h0E01);
      drive_inputs();
      while (bench_count < 2 && k < 30) begin
         sample_edge();
         advance();
         k++;
      end
      n_checks++; if (bench_count !== 2 || m.tvalid !== 1'b1) begin
         n_fails++; $display("FAIL ar_fill: got count %0d tvalid %b want 2/1", bench_count, m.tvalid);
      end
      #3;
      axi_resetn = 1'b0;
      #1;
      n_checks++; if (m.tvalid !== 1'b0) begin n_fails++; $display("FAIL ar_tvalid: got %b want 0", m.tvalid); end
      n_checks++; if (m.tdata !== 256'h0) begin n_fails++; $display("FAIL ar_tdata: got %h want 0", m.tdata); end
      n_checks++; if ({s2.tready, s1.tready, s0.tready} !== 3'b000) begin
         n_fails++; $display("FAIL ar_tready: got %b want 000", {s2.tready, s1.tready, s0.tready});
      end
      do_reset();
      push_pkt(2, 1, 2, 128'h0E02);
      push_pkt(0, 1, 2, 128'h0E00);
      drive_inputs();
      run_until(4, 40, ok);
      n_checks++; if (!ok) begin n_fails++; $display("FAIL ar_post_timeout: got %0d beats want 4", out_q.size()); return; end
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if (out_q[j] !== ((j < 2) ? src0[j] : src2[j - 2])) begin
            n_fails++; $display("FAIL ar_post_beat%0d: got %h want %h", j, out_q[j].d[31:0], (j < 2) ? src0[j].d[31:0] : src2[j - 2].d[31:0]);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      cycle    = 0;
      bench_count = 0;
      acc_now  = '0;
      pop_now  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idx[i] = 0; gap_after[i] = -1; gap_len[i] = 0; gap_cnt[i] = 0;
      end
      s0.tdata = '0; s0.tstrb = '0; s0.tuser = '0; s0.tlast = 1'b0; s0.tvalid = 1'b0;
      s1.tdata = '0; s1.tstrb = '0; s1.tuser = '0; s1.tlast = 1'b0; s1.tvalid = 1'b0;
      s2.tdata = '0; s2.tstrb = '0; s2.tuser = '0; s2.tlast = 1'b0; s2.tvalid = 1'b0;
      m.tready = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_backpressure();
      test_gaps();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
